// File: rtl/calc_key_entry.sv
// Calculator key-entry front end: debounces the raw keypad strobe, decodes
// key codes and runs the operand/operator entry FSM that feeds the display
// and requests the ALU on equals.
module calc_key_entry #(
  parameter int DEBOUNCE_MS = 4,
  parameter int MAX_DIGITS  = 3
) (
  input  logic                      Clock_1ms,
  input  logic                      Reset_n,
  input  logic                      KeyValid,
  input  logic [3:0]                KeyCode,
  input  logic                      Clear,
  input  logic                      ALUdone,
  output logic [2:0]                State,
  output logic [4*MAX_DIGITS-1:0]   memory1,
  output logic [4*MAX_DIGITS-1:0]   memory2,
  output logic [3:0]                operator,
  output logic                      number1Sign,
  output logic                      number2Sign,
  output logic                      ALUstart,
  output logic                      KeyAccept
);

  localparam int MW = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [7:0]    DB_LAST = 8'(DEBOUNCE_MS - 1);
  localparam logic [CW-1:0] DMAX    = CW'(MAX_DIGITS);

  typedef enum logic [2:0] {
    WAIT_SIGN1 = 3'b000,
    ENTER1     = 3'b001,
    WAIT_SIGN2 = 3'b010,
    ENTER2     = 3'b011,
    COMPUTE    = 3'b100,
    RESULT     = 3'b101
  } state_t;

  logic          sync1, sync2, armed, accept, key_evt;
  logic [7:0]    db_cnt;
  logic [3:0]    key_code;
  logic [CW-1:0] dcnt;
  logic          is_digit, is_op, is_sign, is_eq;
  state_t        st;

  assign State  = st;
  // The counter reaching DB_LAST on a high sample is the last of the
  // DEBOUNCE_MS consecutive highs needed while disarmed.
  assign accept = !armed && sync2 && (db_cnt == DB_LAST);

  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_sign  = (key_code == 4'd14);
  assign is_eq    = (key_code == 4'd15);

  // Synchronize the strobe and run the press/release debounce counter.
  always_ff @(posedge Clock_1ms or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      armed     <= 1'b0;
      db_cnt    <= '0;
      key_code  <= '0;
      KeyAccept <= 1'b0;
      key_evt   <= 1'b0;
    end else begin
      sync1     <= KeyValid;
      sync2     <= sync1;
      KeyAccept <= accept;
      // A press accepted under Clear is consumed here, never replayed.
      key_evt   <= accept & ~Clear;
      if (accept) key_code <= KeyCode;
      if (armed) begin
        if (!sync2) begin
          if (db_cnt == DB_LAST) begin
            armed  <= 1'b0;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 8'd1;
          end
        end else begin
          db_cnt <= '0;
        end
      end else begin
        if (sync2) begin
          if (accept) begin
            armed  <= 1'b1;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 8'd1;
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end
  end

  // Entry FSM: builds operands/operator, requests the ALU, waits for done.
  always_ff @(posedge Clock_1ms or negedge Reset_n) begin
    if (!Reset_n) begin
      st          <= WAIT_SIGN1;
      memory1     <= '0;
      memory2     <= '0;
      operator    <= '0;
      number1Sign <= 1'b0;
      number2Sign <= 1'b0;
      ALUstart    <= 1'b0;
      dcnt        <= '0;
    end else begin
      ALUstart <= 1'b0;
      if (Clear) begin
        st          <= WAIT_SIGN1;
        memory1     <= '0;
        memory2     <= '0;
        operator    <= '0;
        number1Sign <= 1'b0;
        number2Sign <= 1'b0;
        dcnt        <= '0;
      end else begin
        case (st)
          WAIT_SIGN1: if (key_evt) begin
            if (is_sign) number1Sign <= ~number1Sign;
            else if (is_digit) begin
              memory1 <= MW'(key_code);
              dcnt    <= CW'(1);
              st      <= ENTER1;
            end
          end
          ENTER1: if (key_evt) begin
            if (is_digit) begin
              if (dcnt < DMAX) begin
                memory1 <= {memory1[MW-5:0], key_code};
                dcnt    <= dcnt + CW'(1);
              end
            end else if (is_op) begin
              operator <= key_code;
              st       <= WAIT_SIGN2;
            end
          end
          WAIT_SIGN2: if (key_evt) begin
            if (is_sign) number2Sign <= ~number2Sign;
            else if (is_op) operator <= key_code;
            else if (is_digit) begin
              memory2 <= MW'(key_code);
              dcnt    <= CW'(1);
              st      <= ENTER2;
            end
          end
          ENTER2: if (key_evt) begin
            if (is_digit) begin
              if (dcnt < DMAX) begin
                memory2 <= {memory2[MW-5:0], key_code};
                dcnt    <= dcnt + CW'(1);
              end
            end else if (is_eq) begin
              ALUstart <= 1'b1;
              st       <= COMPUTE;
            end
          end
          COMPUTE: if (ALUdone) st <= RESULT;
          RESULT: if (key_evt) begin
            if (is_digit) begin
              memory1     <= MW'(key_code);
              memory2     <= '0;
              operator    <= '0;
              number1Sign <= 1'b0;
              number2Sign <= 1'b0;
              dcnt        <= CW'(1);
              st          <= ENTER1;
            end else if (is_sign) begin
              memory1     <= '0;
              memory2     <= '0;
              operator    <= '0;
              number1Sign <= 1'b1;
              number2Sign <= 1'b0;
              dcnt        <= '0;
              st          <= WAIT_SIGN1;
            end
          end
          default: begin
            // Unreachable encodings recover to a clean idle state.
            st          <= WAIT_SIGN1;
            memory1     <= '0;
            memory2     <= '0;
            operator    <= '0;
            number1Sign <= 1'b0;
            number2Sign <= 1'b0;
            dcnt        <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed bench for calc_key_entry: expected display snapshots are queued
// when a key is driven and compared once the FSM has acted on it.
module tb_calc_key_entry;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n, KeyValid, Clear, ALUdone;
  logic [3:0]  KeyCode;
  logic [2:0]  State;
  logic [11:0] memory1, memory2;
  logic [3:0]  operator;
  logic        number1Sign, number2Sign, ALUstart, KeyAccept;

  typedef struct packed {
    logic [2:0]  st;
    logic [11:0] m1;
    logic [11:0] m2;
    logic [3:0]  op;
    logic        s1;
    logic        s2;
  } snap_t;

  snap_t sb[$];
  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int alu_cnt = 0;

  calc_key_entry #(.DEBOUNCE_MS(DEB), .MAX_DIGITS(3)) dut (
    .Clock_1ms(clk), .Reset_n(rst_n), .KeyValid(KeyValid), .KeyCode(KeyCode),
    .Clear(Clear), .ALUdone(ALUdone), .State(State), .memory1(memory1),
    .memory2(memory2), .operator(operator), .number1Sign(number1Sign),
    .number2Sign(number2Sign), .ALUstart(ALUstart), .KeyAccept(KeyAccept)
  );

  always #5 clk = ~clk;

  // Count pulse cycles mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (KeyAccept) acc_cnt <= acc_cnt + 1;
    if (ALUstart)  alu_cnt <= alu_cnt + 1;
  end

  function automatic snap_t mk(input logic [2:0] st, input logic [11:0] m1,
                               input logic [11:0] m2, input logic [3:0] op,
                               input logic s1, input logic s2);
    snap_t s;
    s.st = st; s.m1 = m1; s.m2 = m2; s.op = op; s.s1 = s1; s.s2 = s2;
    return s;
  endfunction

  task automatic chk(input string tag);
    snap_t e, o;
    o = '{State, memory1, memory2, operator, number1Sign, number2Sign};
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard empty observed=%h", tag, o);
    end else begin
      e = sb.pop_front();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  task automatic chk_v(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Press a key, wait for its accept, check the FSM effect one edge later,
  // then release long enough for the debouncer to disarm.
  task automatic press(input logic [3:0] code, input snap_t e, input string tag);
    int n;
    sb.push_back(e);
    @(negedge clk);
    KeyCode  = code;
    KeyValid = 1'b1;
    n = 0;
    while (!KeyAccept && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $error("FAIL %s accept timeout observed=0 expected=1", tag);
      void'(sb.pop_front());
    end else begin
      @(posedge clk); #1;
      chk(tag);
    end
    @(negedge clk);
    KeyValid = 1'b0;
    repeat (DEB + 4) @(negedge clk);
  endtask

  task automatic pulse_done();
    @(negedge clk); ALUdone = 1'b1;
    @(negedge clk); ALUdone = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; KeyValid = 1'b0; KeyCode = '0; Clear = 1'b0; ALUdone = 1'b0;
    repeat (3) @(negedge clk);
    sb.push_back(mk(3'd0, 12'h000, 12'h000, 4'h0, 1'b0, 1'b0));
    chk("reset_state");
    chk_v("reset_alustart", int'(ALUstart), 0);
    chk_v("reset_keyaccept", int'(KeyAccept), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Short glitch must not be accepted.
    KeyCode = 4'd5; KeyValid = 1'b1;
    repeat (3) @(negedge clk);
    KeyValid = 1'b0;
    repeat (DEB + 4) @(negedge clk);
    chk_v("glitch_no_accept", acc_cnt, 0);

    // Exact accept timing on a 10-cycle hold.
    KeyValid = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk_v("accept_edge4_low", int'(KeyAccept), 0);
    @(posedge clk);
    #1 chk_v("accept_edge5_high", int'(KeyAccept), 1);
    chk_v("state_edge5", int'(State), 0);
    @(posedge clk); #1;
    chk_v("accept_edge6_low", int'(KeyAccept), 0);
    sb.push_back(mk(3'd1, 12'h005, 12'h000, 4'h0, 1'b0, 1'b0));
    chk("digit5_edge6");
    repeat (4) @(negedge clk);
    chk_v("held_single_accept", acc_cnt, 1);
    KeyValid = 1'b0;
    repeat (DEB + 4) @(negedge clk);

    // Asynchronous reset mid-ENTER1 with memory1=0x012.
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    press(4'd1, mk(3'd1, 12'h001, 12'h000, 4'h0, 1'b0, 1'b0), "pre_rst_1");
    press(4'd2, mk(3'd1, 12'h012, 12'h000, 4'h0, 1'b0, 1'b0), "pre_rst_2");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(3'd0, 12'h000, 12'h000, 4'h0, 1'b0, 1'b0));
    chk("async_reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Operand 1 with sign, digit overflow ignored, operator latched.
    press(4'd14, mk(3'd0, 12'h000, 12'h000, 4'h0, 1'b1, 1'b0), "sign1");
    press(4'd1,  mk(3'd1, 12'h001, 12'h000, 4'h0, 1'b1, 1'b0), "op1_d1");
    press(4'd2,  mk(3'd1, 12'h012, 12'h000, 4'h0, 1'b1, 1'b0), "op1_d2");
    press(4'd3,  mk(3'd1, 12'h123, 12'h000, 4'h0, 1'b1, 1'b0), "op1_d3");
    press(4'd4,  mk(3'd1, 12'h123, 12'h000, 4'h0, 1'b1, 1'b0), "op1_d4_ignored");
    press(4'd10, mk(3'd2, 12'h123, 12'h000, 4'hA, 1'b1, 1'b0), "op_add");

    // Operand 2 with leading zero, then equals.
    press(4'd0,  mk(3'd3, 12'h123, 12'h000, 4'hA, 1'b1, 1'b0), "op2_d0");
    press(4'd7,  mk(3'd3, 12'h123, 12'h007, 4'hA, 1'b1, 1'b0), "op2_d7");
    press(4'd15, mk(3'd4, 12'h123, 12'h007, 4'hA, 1'b1, 1'b0), "equals");
    chk_v("alustart_once", alu_cnt, 1);
    press(4'd5,  mk(3'd4, 12'h123, 12'h007, 4'hA, 1'b1, 1'b0), "compute_ignore");
    chk_v("alustart_no_repulse", alu_cnt, 1);
    pulse_done();
    sb.push_back(mk(3'd5, 12'h123, 12'h007, 4'hA, 1'b1, 1'b0));
    chk("alu_done");

    // RESULT: digit restarts, sign restarts negative.
    press(4'd9,  mk(3'd1, 12'h009, 12'h000, 4'h0, 1'b0, 1'b0), "result_digit");
    press(4'd13, mk(3'd2, 12'h009, 12'h000, 4'hD, 1'b0, 1'b0), "op_mul");
    press(4'd2,  mk(3'd3, 12'h009, 12'h002, 4'hD, 1'b0, 1'b0), "op2b_d2");
    press(4'd15, mk(3'd4, 12'h009, 12'h002, 4'hD, 1'b0, 1'b0), "equals2");
    chk_v("alustart_second", alu_cnt, 2);
    pulse_done();
    sb.push_back(mk(3'd5, 12'h009, 12'h002, 4'hD, 1'b0, 1'b0));
    chk("alu_done2");
    press(4'd14, mk(3'd0, 12'h000, 12'h000, 4'h0, 1'b1, 1'b0), "result_sign");

    // Clear coincident with a digit accept in ENTER2.
    press(4'd1,  mk(3'd1, 12'h001, 12'h000, 4'h0, 1'b1, 1'b0), "c_d1");
    press(4'd11, mk(3'd2, 12'h001, 12'h000, 4'hB, 1'b1, 1'b0), "c_sub");
    press(4'd3,  mk(3'd3, 12'h001, 12'h003, 4'hB, 1'b1, 1'b0), "c_d3");
    base = acc_cnt;
    @(negedge clk);
    KeyCode = 4'd4; KeyValid = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); Clear = 1'b1;
    @(posedge clk); #1;
    chk_v("clear_accept_seen", int'(KeyAccept), 1);
    @(negedge clk); Clear = 1'b0;
    @(posedge clk); #1;
    sb.push_back(mk(3'd0, 12'h000, 12'h000, 4'h0, 1'b0, 1'b0));
    chk("clear_wins");
    @(negedge clk); KeyValid = 1'b0;
    repeat (DEB + 4) @(negedge clk);
    sb.push_back(mk(3'd0, 12'h000, 12'h000, 4'h0, 1'b0, 1'b0));
    chk("clear_key_lost");
    chk_v("clear_one_accept", acc_cnt - base, 1);

    // ALUdone outside COMPUTE is ignored.
    pulse_done();
    sb.push_back(mk(3'd0, 12'h000, 12'h000, 4'h0, 1'b0, 1'b0));
    chk("done_ignored");
    chk_v("alustart_total", alu_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_key_entry.md
Name: calc_key_entry

Overview:
- Front-end entry controller for the calculator: the writer side of the display path.
- Debounces raw keypad strobes and decodes key codes.
- Builds two signed 3-digit BCD operands plus an operator.
- Runs the calculator FSM whose State, memory1/memory2, operator and sign outputs drive the 7-seg display block; requests the ALU on equals and holds until the ALU reports done.

Parameters:
- DEBOUNCE_MS, 4: consecutive Clock_1ms samples a key level must hold before a press or release is accepted (range 1..255).
- MAX_DIGITS, 3: BCD digits per operand; further digits are ignored.

Ports:
- Clock_1ms  input  1  1 ms system clock; all logic rising-edge.
- Reset_n  input  1  asynchronous active-low reset.
- KeyValid  input  1  raw, asynchronous keypad strobe, high while a key is held.
- KeyCode  input  4  raw key code: 0-9 digit, 1010 add, 1011 sub, 1100 div, 1101 mul, 1110 sign, 1111 equals.
- Clear  input  1  synchronous clear request, level.
- ALUdone  input  1  one-cycle pulse: ALU result valid.
- State  output  3  FSM state (encoding below).
- memory1  output  12  operand 1, BCD {hundreds, tens, ones}.
- memory2  output  12  operand 2, BCD.
- operator  output  4  latched operator code (1010..1101).
- number1Sign  output  1  1 = operand 1 negative.
- number2Sign  output  1  1 = operand 2 negative.
- ALUstart  output  1  one-cycle pulse requesting computation.
- KeyAccept  output  1  one-cycle pulse per debounced press (diagnostic).

Behaviour:
Reset and clock:
- One clock; Reset_n asynchronous active-low.
- Reset clears all outputs to 0 and returns State to 000.
- Reset mid-entry or mid-ALU discards everything; no ALUstart is issued.

Debounce:
- KeyValid passes through a 2-flop synchronizer; KeyCode is sampled at acceptance.
- Press accepted after DEBOUNCE_MS consecutive high synchronized samples while disarmed. KeyAccept then pulses for one cycle and the module arms.
- Re-disarms only after DEBOUNCE_MS consecutive low samples; holding a key yields exactly one press.
- Glitches shorter than DEBOUNCE_MS are ignored.
- Timing: the first edge sampling KeyValid high is edge 0. KeyAccept is high after edge DEBOUNCE_MS+1; register effects are visible after edge DEBOUNCE_MS+2.

Digit shift:
- Digit d into operand M with count c: if c<MAX_DIGITS, M <= {M[7:0], d} and c+1; otherwise ignored.
- Leading zero counts as a digit.

FSM (key events = accepted presses):
- 000 WAIT_SIGN1:
  - sign: toggle number1Sign.
  - digit: memory1=d, c=1 -> 001.
  - others ignored.
- 001 ENTER1:
  - digit: shift.
  - operator key: latch operator -> 010.
  - sign/equals ignored.
- 010 WAIT_SIGN2:
  - sign: toggle number2Sign.
  - operator key: overwrite operator.
  - digit: memory2=d, c=1 -> 011.
  - equals ignored.
- 011 ENTER2:
  - digit: shift.
  - equals: ALUstart pulses for the cycle of the transition -> 100.
  - operator/sign ignored.
- 100 COMPUTE:
  - all keys ignored.
  - ALUdone -> 101.
  - ALUstart never re-pulses.
- 101 RESULT:
  - digit: clear memory1/memory2/signs/operator, memory1=d, c=1 -> 001.
  - sign: clear all, number1Sign=1 -> 000.
  - others ignored.
  - ALUdone ignored.
- Encodings 110/111 are unreachable; if ever entered, force 000 with outputs cleared on the next edge.

Clear and simultaneous events:
- Clear high at an edge, in any state: operands, signs and operator cleared, State=000.
- Clear has priority over a coincident key accept; that key is consumed, not replayed.
- ALUdone outside 100 is ignored.
- ALUdone coincident with Clear: Clear wins.

Test Plan:
- Reset_n low mid-ENTER1 with memory1=0x012 -> all outputs 0, State=000 immediately (asynchronous).
- DEBOUNCE_MS=4; KeyValid high 3 cycles then low; then high 10 cycles with KeyCode=0101 -> no effect from the glitch. KeyAccept once, after edge 5. memory1=0x005, State=001 after edge 6. No second accept while held.
- Sequence: sign, 1, 2, 3, 4, 1010 -> number1Sign=1, memory1=0x123 (4 ignored), operator=1010, State=010.
- Sequence: 0, 7, equals from 010 -> memory2=0x007; ALUstart exactly one cycle; State=100. Extra keys ignored. ALUdone -> State=101.
- In 101, digit 9 -> memory1=0x009, memory2=0, signs 0, State=001. Separately, sign key in 101 -> State=000, number1Sign=1.
- Clear asserted on the same edge a digit is accepted in ENTER2 -> State=000, memory2=0; the digit is lost.
